// File: rtl/uart_cfg_pkg.sv
// Shared constants and state encodings for the UART16550 configuration master.
package uart_cfg_pkg;

  localparam logic [12:0] OFF_RBR_THR = 13'h000;
  localparam logic [12:0] OFF_DLL     = 13'h000;
  localparam logic [12:0] OFF_IER_DLM = 13'h004;
  localparam logic [12:0] OFF_FCR     = 13'h008;
  localparam logic [12:0] OFF_LCR     = 13'h00C;
  localparam logic [12:0] OFF_LSR     = 13'h014;

  localparam int LSR_THRE_BIT = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_LCR_DLAB,
    S_W_DLL,
    S_W_DLM,
    S_W_LCR,
    S_W_FCR,
    S_W_IER,
    S_TX_LSR,
    S_TX_THR
  } state_t;

  typedef enum logic [2:0] {
    B_IDLE,
    B_WADDR,
    B_WRESP,
    B_RADDR,
    B_RDATA
  } beat_t;

  function automatic logic [7:0] lcr_byte(input logic dlab, input logic even,
                                          input logic parity, input logic stop2,
                                          input logic [1:0] wlen);
    return {dlab, 2'b00, even, parity, stop2, wlen};
  endfunction

endpackage

// File: rtl/uart_axil_beat.sv
// One AXI4-Lite write or read transaction with a per-beat handshake timeout.
// UART_CFG_THRE_POLL_EN enables the read channel; otherwise arvalid/rready stay 0.
module uart_axil_beat
  import uart_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TW             = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_read,
  input  logic [12:0] addr,
  input  logic [7:0]  data,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [12:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [12:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  beat_t          st, st_n;
  logic           awv, wv;
  logic [TW-1:0]  cnt;
  logic [12:0]    addr_q;
  logic [7:0]     data_q;
  logic           aw_hs, w_hs, timeout;

  assign aw_hs   = awv & m_axi_awready;
  assign w_hs    = wv & m_axi_wready;
  assign timeout = (st != B_IDLE) && (cnt == CNT_LAST);

  always_comb begin
    st_n = st;
    done = 1'b0;
    err  = 1'b0;
    case (st)
      B_IDLE:  if (req) st_n = is_read ? B_RADDR : B_WADDR;
      // AW and W may be accepted in either order; wait for both
      B_WADDR: if ((!awv || aw_hs) && (!wv || w_hs)) st_n = B_WRESP;
      B_WRESP: if (m_axi_bvalid) begin
        done = 1'b1;
        err  = (m_axi_bresp != RESP_OKAY);
        st_n = B_IDLE;
      end
      B_RADDR: if (m_axi_arready) st_n = B_RDATA;
      B_RDATA: if (m_axi_rvalid) begin
        done = 1'b1;
        err  = (m_axi_rresp != RESP_OKAY);
        st_n = B_IDLE;
      end
      default: st_n = B_IDLE;
    endcase
    // a response landing on the last allowed cycle still counts as success
    if (timeout && !done) begin
      done = 1'b1;
      err  = 1'b1;
      st_n = B_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= B_IDLE;
      awv    <= 1'b0;
      wv     <= 1'b0;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      st <= st_n;
      if (st == B_IDLE) begin
        cnt <= '0;
        if (req) begin
          awv    <= ~is_read;
          wv     <= ~is_read;
          addr_q <= addr;
          data_q <= data;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (aw_hs) awv <= 1'b0;
        if (w_hs)  wv  <= 1'b0;
      end
      if (done) begin
        awv <= 1'b0;
        wv  <= 1'b0;
      end
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awv;
  assign m_axi_wdata   = {24'h0, data_q};
  assign m_axi_wstrb   = {3'b000, wv};
  assign m_axi_wvalid  = wv;
  assign m_axi_bready  = (st == B_WRESP);
  assign m_axi_araddr  = addr_q;
  assign rdata         = m_axi_rdata;

`ifdef UART_CFG_THRE_POLL_EN
  assign m_axi_arvalid = (st == B_RADDR);
  assign m_axi_rready  = (st == B_RDATA);
`else
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
`endif

endmodule

// File: rtl/uart_cfg_master.sv
// AXI4-Lite master that programs a UART16550 from one start pulse, then feeds THR.
// UART_CFG_THRE_POLL_EN: poll LSR.THRE before every THR write.
module uart_cfg_master
  import uart_cfg_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR      = 13'h1000,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          TW             = 9
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        start,
  input  logic [1:0]  cfg_wlen,
  input  logic        cfg_stop2,
  input  logic        cfg_parity,
  input  logic        cfg_even,
  input  logic [15:0] cfg_div,
  input  logic [1:0]  cfg_trig,
  input  logic [3:0]  cfg_ier,
  output logic        busy,
  output logic        configured,
  output logic        err,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [12:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [12:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

`ifdef UART_CFG_THRE_POLL_EN
  localparam state_t TX_FIRST = S_TX_LSR;
`else
  localparam state_t TX_FIRST = S_TX_THR;
`endif

  state_t      state, state_n;
  logic        issued;
  logic [1:0]  wlen_q, trig_q;
  logic        stop2_q, parity_q, even_q;
  logic [15:0] div_q;
  logic [3:0]  ier_q;
  logic [7:0]  tx_q;
  logic        err_q, cfg_ok;

  logic        req, is_read, tx_go;
  logic [12:0] off;
  logic [7:0]  wd;
  logic        beat_done, beat_err;
  logic [31:0] beat_rdata;
  logic        unused_rdata;

  assign tx_go = cfg_ok & tx_valid;
  // one request per beat state; issued holds it off until the beat completes
  assign req   = (state != S_IDLE) && !issued;
  assign unused_rdata = ^{beat_rdata[31:LSR_THRE_BIT+1], beat_rdata[LSR_THRE_BIT-1:0]};

  always_comb begin
    state_n  = state;
    off      = OFF_LCR;
    wd       = 8'h00;
    is_read  = 1'b0;
    tx_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)      state_n = S_W_LCR_DLAB;
        else if (tx_go) state_n = TX_FIRST;
      end
      S_W_LCR_DLAB: begin
        off = OFF_LCR;
        wd  = lcr_byte(1'b1, even_q, parity_q, stop2_q, wlen_q);
        if (beat_done) state_n = S_W_DLL;
      end
      S_W_DLL: begin
        off = OFF_DLL;
        wd  = div_q[7:0];
        if (beat_done) state_n = S_W_DLM;
      end
      S_W_DLM: begin
        off = OFF_IER_DLM;
        wd  = div_q[15:8];
        if (beat_done) state_n = S_W_LCR;
      end
      S_W_LCR: begin
        off = OFF_LCR;
        wd  = lcr_byte(1'b0, even_q, parity_q, stop2_q, wlen_q);
        if (beat_done) state_n = S_W_FCR;
      end
      S_W_FCR: begin
        off = OFF_FCR;
        wd  = {trig_q, 2'b00, 1'b1, 2'b00, 1'b1};
        if (beat_done) state_n = S_W_IER;
      end
      S_W_IER: begin
        off = OFF_IER_DLM;
        wd  = {4'b0000, ier_q};
        if (beat_done) state_n = S_IDLE;
      end
      S_TX_LSR: begin
        off     = OFF_LSR;
        is_read = 1'b1;
        // THRE clear: stay here and issue another read
        if (beat_done && beat_rdata[LSR_THRE_BIT]) state_n = S_TX_THR;
      end
      S_TX_THR: begin
        off = OFF_RBR_THR;
        wd  = tx_q;
        if (beat_done) begin
          state_n  = S_IDLE;
          tx_ready = ~beat_err;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (beat_done && beat_err) state_n = S_IDLE;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state    <= S_IDLE;
      issued   <= 1'b0;
      wlen_q   <= '0;
      trig_q   <= '0;
      stop2_q  <= 1'b0;
      parity_q <= 1'b0;
      even_q   <= 1'b0;
      div_q    <= '0;
      ier_q    <= '0;
      tx_q     <= '0;
      err_q    <= 1'b0;
      cfg_ok   <= 1'b0;
    end else begin
      state  <= state_n;
      issued <= req | (issued & ~beat_done);
      if (state == S_IDLE && start) begin
        wlen_q   <= cfg_wlen;
        trig_q   <= cfg_trig;
        stop2_q  <= cfg_stop2;
        parity_q <= cfg_parity;
        even_q   <= cfg_even;
        div_q    <= cfg_div;
        ier_q    <= cfg_ier;
        err_q    <= 1'b0;
        cfg_ok   <= 1'b0;
      end else if (state == S_IDLE && tx_go) begin
        tx_q <= tx_data;
      end
      if (beat_done && beat_err) begin
        err_q  <= 1'b1;
        cfg_ok <= 1'b0;
      end else if (beat_done && state == S_W_IER) begin
        cfg_ok <= 1'b1;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign configured = cfg_ok;
  assign err        = err_q;

  uart_axil_beat #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_beat (
    .clk          (s_axi_aclk),
    .rst_n        (s_axi_aresetn),
    .req          (req),
    .is_read      (is_read),
    .addr         (BASE_ADDR + off),
    .data         (wd),
    .done         (beat_done),
    .err          (beat_err),
    .rdata        (beat_rdata),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

endmodule

// File: tb/tb_uart_cfg_master.sv
// Directed bench for uart_cfg_master: reactive AXI-Lite slave plus a write scoreboard.
module tb_uart_cfg_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [1:0]  cfg_wlen = '0, cfg_trig = '0;
  logic        cfg_stop2 = 1'b0, cfg_parity = 1'b0, cfg_even = 1'b0;
  logic [15:0] cfg_div = '0;
  logic [3:0]  cfg_ier = '0;
  logic        busy, configured, err, tx_ready;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic [12:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;

  uart_cfg_master dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start),
    .cfg_wlen(cfg_wlen), .cfg_stop2(cfg_stop2), .cfg_parity(cfg_parity), .cfg_even(cfg_even),
    .cfg_div(cfg_div), .cfg_trig(cfg_trig), .cfg_ier(cfg_ier),
    .busy(busy), .configured(configured), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct packed { logic [12:0] a; logic [7:0] d; } wr_t;
  wr_t sb[$];

  int ntot = 0, npass = 0;

  // slave knobs, written only by the stimulus process
  int aw_delay = 0;
  int bad_beat = -1;
  bit hold_b   = 1'b0;
  logic [2:0] lsr_thre = 3'b100;

  // slave state and event counters, written only by the slave process
  int nbeat = 0, aw_hi = 0, w_hi = 0, nar = 0, nread = 0, ntx = 0, aw_cnt = 0;
  bit got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
  logic [12:0] cap_a;
  logic [31:0] cap_d;
  logic [3:0]  cap_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive on the falling edge from registered DUT outputs, then observe what
  // will handshake at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      awready = awvalid && !got_aw && (aw_cnt == aw_delay);
      wready  = wvalid && !got_w;
      bvalid  = got_aw && got_w && !hold_b;
      bresp   = (nbeat == bad_beat) ? 2'b10 : 2'b00;
      arready = arvalid && !got_ar;
      rvalid  = got_ar;
      rdata   = {26'h0, lsr_thre[(nread > 2) ? 2 : nread], 5'h0};
      #1;
      if (awvalid) begin
        aw_hi++;
        if (awready) begin got_aw = 1'b1; cap_a = awaddr; aw_cnt = 0; end
        else aw_cnt++;
      end
      if (wvalid) begin
        w_hi++;
        if (wready) begin got_w = 1'b1; cap_d = wdata; cap_s = wstrb; end
      end
      if (bvalid && bready) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", 32'(cap_a), 32'(e.a));
          chk("wr_data", cap_d, {24'h0, e.d});
          chk("wr_strb", 32'(cap_s), 32'h1);
        end
        nbeat++;
        got_aw = 1'b0;
        got_w  = 1'b0;
      end
      if (arready) begin
        chk("ar_addr", 32'(araddr), 32'h1014);
        got_ar = 1'b1;
        nar++;
      end
      if (rvalid && rready) begin got_ar = 1'b0; nread++; end
      if (tx_ready) ntx++;
    end
  end

  task automatic push(input logic [12:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_cfg(input logic [7:0] lcr, input logic [15:0] div,
                          input logic [7:0] fcr, input logic [7:0] ier);
    push(13'h100C, lcr | 8'h80);
    push(13'h1000, div[7:0]);
    push(13'h1004, div[15:8]);
    push(13'h100C, lcr);
    push(13'h1008, fcr);
    push(13'h1004, ier);
  endtask

  task automatic wait_idle(input int maxc, output int cyc);
    cyc = 0;
    while (busy && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_within_bound", 32'(cyc < maxc), 32'd1);
  endtask

  // Start pulse, then scramble cfg_* to show they were captured on the start cycle.
  task automatic run_cfg(input logic [1:0] wl, input logic s2, input logic par,
                         input logic ev, input logic [15:0] dv, input logic [1:0] tr,
                         input logic [3:0] ie, output int cyc);
    @(negedge clk);
    cfg_wlen = wl; cfg_stop2 = s2; cfg_parity = par; cfg_even = ev;
    cfg_div = dv; cfg_trig = tr; cfg_ier = ie;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_wlen = ~wl; cfg_stop2 = ~s2; cfg_parity = ~par; cfg_even = ~ev;
    cfg_div = ~dv; cfg_trig = ~tr; cfg_ier = ~ie;
    wait_idle(2000, cyc);
  endtask

  initial begin
    int cyc, b0, awh0, wh0, ar0, tx0, k;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {23'h0, awvalid, wvalid, bready, arvalid, rready, busy, configured, err, tx_ready}, 32'h0);
    chk("rst_awaddr", 32'(awaddr), 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_wstrb", 32'(wstrb), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1, div 0x0036, trig 14, ier 7
    push_cfg(8'h03, 16'h0036, 8'hC9, 8'h07);
    b0 = nbeat; awh0 = aw_hi;
    run_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'h0036, 2'd3, 4'h7, cyc);
    chk("8n1_configured", 32'(configured), 32'd1);
    chk("8n1_err", 32'(err), 32'd0);
    chk("8n1_beats", 32'(nbeat - b0), 32'd6);
    chk("8n1_aw_cycles", 32'(aw_hi - awh0), 32'd6);
    chk("8n1_sb_drained", 32'(sb.size()), 32'd0);

    // single transmit byte
    push(13'h1000, 8'h41);
    ar0 = nar; tx0 = ntx;
    @(negedge clk);
    tx_data = 8'h41; tx_valid = 1'b1;
    k = 0;
    while (k < 500) begin
      @(negedge clk);
      #2;
      if (tx_ready) break;
      k++;
    end
    tx_valid = 1'b0;
    chk("tx_ready_seen", 32'(k < 500), 32'd1);
    repeat (3) @(negedge clk);
    chk("tx_idle", 32'(busy), 32'd0);
    chk("tx_pulses", 32'(ntx - tx0), 32'd1);
`ifdef UART_CFG_THRE_POLL_EN
    chk("tx_lsr_reads", 32'(nar - ar0), 32'd3);
`else
    chk("tx_lsr_reads", 32'(nar - ar0), 32'd0);
`endif
    chk("tx_sb_drained", 32'(sb.size()), 32'd0);

    // 7E2: LCR 0x9E with DLAB, 0x1E after
    push_cfg(8'h1E, 16'h0001, 8'h09, 8'h00);
    run_cfg(2'd2, 1'b1, 1'b1, 1'b1, 16'h0001, 2'd0, 4'h0, cyc);
    chk("7e2_configured", 32'(configured), 32'd1);
    chk("7e2_sb_drained", 32'(sb.size()), 32'd0);

    // awready 3 cycles late, wready immediate
    aw_delay = 3;
    push_cfg(8'h03, 16'h0036, 8'hC9, 8'h07);
    b0 = nbeat; awh0 = aw_hi; wh0 = w_hi;
    run_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'h0036, 2'd3, 4'h7, cyc);
    aw_delay = 0;
    chk("awdly_aw_cycles", 32'(aw_hi - awh0), 32'd24);
    chk("awdly_w_cycles", 32'(w_hi - wh0), 32'd6);
    chk("awdly_beats", 32'(nbeat - b0), 32'd6);
    chk("awdly_configured", 32'(configured), 32'd1);

    // SLVERR on the DLL beat
    bad_beat = nbeat + 1;
    push(13'h100C, 8'h83);
    push(13'h1000, 8'h36);
    b0 = nbeat;
    run_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'h0036, 2'd3, 4'h7, cyc);
    bad_beat = -1;
    chk("slverr_err", 32'(err), 32'd1);
    chk("slverr_configured", 32'(configured), 32'd0);
    repeat (4) @(negedge clk);
    chk("slverr_beats", 32'(nbeat - b0), 32'd2);
    chk("slverr_sb_drained", 32'(sb.size()), 32'd0);
    chk("slverr_idle_busy", 32'(busy), 32'd0);

    // fresh start clears err and completes
    push_cfg(8'h03, 16'h0036, 8'hC9, 8'h07);
    @(negedge clk);
    cfg_wlen = 2'd3; cfg_stop2 = 1'b0; cfg_parity = 1'b0; cfg_even = 1'b0;
    cfg_div = 16'h0036; cfg_trig = 2'd3; cfg_ier = 4'h7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_err_clear", 32'(err), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_idle(2000, cyc);
    chk("restart_configured", 32'(configured), 32'd1);
    chk("restart_sb_drained", 32'(sb.size()), 32'd0);

    // bvalid withheld: timeout after TIMEOUT_CYCLES
    hold_b = 1'b1;
    run_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'h0036, 2'd3, 4'h7, cyc);
    chk("tmo_window", 32'(cyc >= 250 && cyc <= 265), 32'd1);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_configured", 32'(configured), 32'd0);
    chk("tmo_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
